// File: rtl/frame_downscale_writer.sv
// Purpose : box-average a raster pixel stream (1x1, 2x2 or 4x2) and write one
//           8-bit sample per box into an OUT_W x OUT_H frame buffer.
//           Each capture request fills exactly one frame.
// Latency : wr_en_out fires exactly 2 cycles after the pixel that completes a box.
// Backpressure: none. pixel_valid_in low is a stall, and the source is never throttled.
// Ports   : clk_in/rst_in          clock, synchronous active-high reset
//           scale_in               box select (00/01=1x1, 11=2x2, 10=4x2), latched at frame start
//           capture_req_in         arms a one-frame capture
//           hcount/vcount/pixel/pixel_valid_in  camera raster stream
//           busy_out               capture armed or in progress
//           wr_en/addr/data_out    frame buffer write port
//           frame_done/err_out     one-cycle completion / abort pulses
module frame_downscale_writer #(
   parameter int OUT_W  = 240,
   parameter int OUT_H  = 320,
   parameter int ADDR_W = 17
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic [1:0]        scale_in,
   input  logic              capture_req_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic [7:0]        pixel_in,
   input  logic              pixel_valid_in,
   output logic              busy_out,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [7:0]        wr_data_out,
   output logic              frame_done_out,
   output logic              frame_err_out
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_ERR     = 3'd4;

   localparam int              IDX_W     = $clog2(OUT_W);
   localparam logic [10:0]     OUT_W_L   = 11'(OUT_W);
   localparam logic [9:0]      OUT_H_L   = 10'(OUT_H);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H - 1);

   logic [2:0]        state_q, state_d;
   logic [1:0]        scale_q, scale_d;
   logic [10:0]       hsum_q, hsum_d;
   logic              s1_vld_q, s1_vld_d;
   logic [10:0]       s1_sh_q, s1_sh_d;
   logic [9:0]        s1_sv_q, s1_sv_d;
   logic [7:0]        s1_dat_q, s1_dat_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [10:0]       row_acc_q [OUT_W];

   logic              origin;
   logic [1:0]        eff_scale;
   logic [1:0]        shift_h;
   logic              shift_v;
   logic [10:0]       mask_h;
   logic [9:0]        mask_v;
   logic              h_first, h_last, v_first, v_last;
   logic [10:0]       pix_sh;
   logic [9:0]        pix_sv;
   logic              in_range, accept;
   logic [10:0]       hsum_part, total;
   logic [IDX_W-1:0]  acc_idx;
   logic              row_wr, box_done;

   always_comb begin
      origin = pixel_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
      // The frame-start pixel itself must use the scale being latched with it.
      eff_scale = (state_q == ST_ARMED) ? scale_in : scale_q;

      shift_h = 2'd0;
      shift_v = 1'b0;
      case (eff_scale)
         2'b11:   begin shift_h = 2'd1; shift_v = 1'b1; end
         2'b10:   begin shift_h = 2'd2; shift_v = 1'b1; end
         default: begin shift_h = 2'd0; shift_v = 1'b0; end
      endcase

      mask_h  = (11'd1 << shift_h) - 11'd1;
      mask_v  = {9'd0, shift_v};
      h_first = (hcount_in & mask_h) == 11'd0;
      h_last  = (hcount_in & mask_h) == mask_h;
      v_first = (vcount_in & mask_v) == 10'd0;
      v_last  = (vcount_in & mask_v) == mask_v;

      pix_sh   = hcount_in >> shift_h;
      pix_sv   = vcount_in >> shift_v;
      in_range = (pix_sh < OUT_W_L) && (pix_sv < OUT_H_L);

      // Frame-start pixel is consumed when arming, but aborts an ongoing capture.
      accept = pixel_valid_in && in_range &&
               (((state_q == ST_CAPTURE) && !origin) ||
                ((state_q == ST_ARMED) && origin));

      hsum_part = h_first ? {3'd0, pixel_in} : hsum_q + {3'd0, pixel_in};
      hsum_d    = accept ? hsum_part : hsum_q;

      acc_idx  = pix_sh[IDX_W-1:0];
      total    = row_acc_q[acc_idx] + hsum_part;
      // Only multi-row boxes park a partial sum; 1x1 has v_first == v_last.
      row_wr   = accept && h_last && v_first && !v_last;
      box_done = accept && h_last && v_last;

      s1_vld_d = box_done;
      s1_sh_d  = pix_sh;
      s1_sv_d  = pix_sv;
      case (eff_scale)
         2'b11:   s1_dat_d = 8'(total >> 2);
         2'b10:   s1_dat_d = 8'(total >> 3);
         default: s1_dat_d = pixel_in;
      endcase

      state_d = state_q;
      scale_d = scale_q;
      case (state_q)
         ST_IDLE:  if (capture_req_in) state_d = ST_ARMED;
         ST_ARMED: if (origin) begin
                      state_d = ST_CAPTURE;
                      scale_d = scale_in;
                   end
         ST_CAPTURE: begin
            // The write of the last address finishes the frame even if a new
            // frame starts in the same cycle.
            if (wr_en_q && (wr_addr_q == LAST_ADDR)) state_d = ST_DONE;
            else if (origin)                         state_d = ST_ERR;
         end
         default:  state_d = ST_IDLE;
      endcase

      // Writes are only emitted while the capture stays live, so an abort
      // discards whatever is still in the pipeline.
      wr_en_d   = s1_vld_q && (state_d == ST_CAPTURE);
      wr_addr_d = ADDR_W'(s1_sv_q) * ADDR_W'(OUT_W) + ADDR_W'(s1_sh_q);
      wr_data_d = s1_dat_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= ST_IDLE;
         scale_q   <= 2'd0;
         hsum_q    <= 11'd0;
         s1_vld_q  <= 1'b0;
         s1_sh_q   <= 11'd0;
         s1_sv_q   <= 10'd0;
         s1_dat_q  <= 8'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'd0;
         for (int i = 0; i < OUT_W; i++) row_acc_q[i] <= 11'd0;
      end else begin
         state_q   <= state_d;
         scale_q   <= scale_d;
         hsum_q    <= hsum_d;
         s1_vld_q  <= s1_vld_d;
         s1_sh_q   <= s1_sh_d;
         s1_sv_q   <= s1_sv_d;
         s1_dat_q  <= s1_dat_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         if (row_wr) row_acc_q[acc_idx] <= hsum_part;
      end
   end

   assign busy_out       = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign frame_done_out = (state_q == ST_DONE);
   assign frame_err_out  = (state_q == ST_ERR);
   assign wr_en_out      = wr_en_q;
   assign wr_addr_out    = wr_addr_q;
   assign wr_data_out    = wr_data_q;

endmodule

// File: tb/tb_frame_downscale_writer.sv
// Bench for frame_downscale_writer on a reduced 16x8 output frame.
// Expected writes (address, data, cycle) are queued as pixels are driven and
// compared in order as the DUT writes them.
module tb_frame_downscale_writer;

   localparam int OW = 16;
   localparam int OH = 8;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst_in;
   logic [1:0]    scale_in;
   logic          capture_req_in;
   logic [10:0]   hcount_in;
   logic [9:0]    vcount_in;
   logic [7:0]    pixel_in;
   logic          pixel_valid_in;
   logic          busy_out;
   logic          wr_en_out;
   logic [AW-1:0] wr_addr_out;
   logic [7:0]    wr_data_out;
   logic          frame_done_out;
   logic          frame_err_out;

   frame_downscale_writer #(.OUT_W(OW), .OUT_H(OH), .ADDR_W(AW)) dut (
      .clk_in(clk), .rst_in(rst_in), .scale_in(scale_in),
      .capture_req_in(capture_req_in), .hcount_in(hcount_in),
      .vcount_in(vcount_in), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
      .busy_out(busy_out), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
      .wr_data_out(wr_data_out), .frame_done_out(frame_done_out),
      .frame_err_out(frame_err_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   pix [0:15][0:63];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Write monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (wr_en_out) begin
         if (expq.size() == 0) begin
            chk("wr_unexpected", int'(wr_addr_out), -1);
         end else begin
            mon_e = expq.pop_front();
            chk("wr_addr", int'(wr_addr_out), mon_e.addr);
            chk("wr_data", int'(wr_data_out), mon_e.data);
            chk("wr_latency", cyc, mon_e.cyc);
         end
      end
      if (frame_done_out) begin
         done_cnt++;
         chk("done_queue_empty", expq.size(), 0);
      end
      if (frame_err_out) err_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pixel_valid_in = 1'b0;
         hcount_in      = 11'($urandom_range(0, 2047));
         vcount_in      = 10'($urandom_range(0, 1023));
         pixel_in       = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic drive_pix(input int h, input int v, input int p);
      @(negedge clk);
      hcount_in      = 11'(h);
      vcount_in      = 10'(v);
      pixel_in       = 8'(p);
      pixel_valid_in = 1'b1;
   endtask

   task automatic req_pulse();
      @(negedge clk);
      pixel_valid_in = 1'b0;
      capture_req_in = 1'b1;
      @(negedge clk);
      capture_req_in = 1'b0;
   endtask

   function automatic int pat(input int mode, input int h, input int v);
      int r;
      r = 0;
      case (mode)
         0: r = (h + v) % 256;
         1: begin
            if (h < 2 && v < 2) begin
               case (v * 2 + h)
                  0: r = 10;
                  1: r = 20;
                  2: r = 30;
                  default: r = 41;
               endcase
            end else r = 200;
         end
         default: begin
            if (v < 2 && h >= 4 && h < 8) r = v * 4 + (h - 4) + 1;
            else r = $urandom_range(0, 255);
         end
      endcase
      return r;
   endfunction

   // Drive one pixel; if it closes an in-range box, queue the expected write.
   task automatic send(input int h, input int v, input int p,
                       input int bh, input int bv, input bit exp_on);
      int   sum;
      exp_t e;
      pix[v][h] = p;
      drive_pix(h, v, p);
      if (exp_on && (h % bh) == bh - 1 && (v % bv) == bv - 1 &&
          (h / bh) < OW && (v / bv) < OH) begin
         sum = 0;
         for (int dv = 0; dv < bv; dv++)
            for (int dh = 0; dh < bh; dh++)
               sum += pix[v - dv][h - dh];
         e.addr = (v / bv) * OW + h / bh;
         e.data = sum / (bh * bv);
         e.cyc  = cyc + 2;
         expq.push_back(e);
      end
      if ($urandom_range(0, 5) == 0) idle(1);
   endtask

   task automatic send_rows(input int mode, input int sw, input int v0, input int v1,
                            input int bh, input int bv, input bit exp_on);
      for (int v = v0; v < v1; v++)
         for (int h = 0; h < sw; h++)
            send(h, v, pat(mode, h, v), bh, bv, exp_on);
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_wr_en"}, int'(wr_en_out), 0);
      chk({pfx, "_wr_addr"}, int'(wr_addr_out), 0);
      chk({pfx, "_wr_data"}, int'(wr_data_out), 0);
      chk({pfx, "_busy"}, int'(busy_out), 0);
      chk({pfx, "_done"}, int'(frame_done_out), 0);
      chk({pfx, "_err"}, int'(frame_err_out), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 1'b1; scale_in = 2'b00; capture_req_in = 1'b0;
      hcount_in = '0; vcount_in = '0; pixel_in = '0; pixel_valid_in = 1'b0;
      for (int v = 0; v < 16; v++)
         for (int h = 0; h < 64; h++) pix[v][h] = 0;
      idle(3);
      chk_outputs_zero("reset");
      rst_in = 1'b0;
      idle(2);

      // 1x1 ramp frame; non-origin pixels while armed are ignored.
      scale_in = 2'b00;
      req_pulse();
      chk("t1_busy_armed", int'(busy_out), 1);
      send(3, 2, 77, 1, 1, 1'b0);
      send(5, 1, 66, 1, 1, 1'b0);
      send_rows(0, OW, 0, OH, 1, 1, 1'b1);
      idle(6);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_err_cnt", err_cnt, 0);
      chk("t1_busy_after", int'(busy_out), 0);
      chk("t1_queue_empty", expq.size(), 0);

      // 2x2 box, constant 200 with a known first box (avg 25).
      scale_in = 2'b11;
      req_pulse();
      send_rows(1, 2 * OW, 0, 2 * OH, 2, 2, 1'b1);
      idle(6);
      chk("t2_done_cnt", done_cnt, 2);
      chk("t2_queue_empty", expq.size(), 0);

      // 4x2 box, random pixels with a known box at (1,0) (avg 4).
      scale_in = 2'b10;
      req_pulse();
      send_rows(2, 4 * OW, 0, 2 * OH, 4, 2, 1'b1);
      idle(6);
      chk("t3_done_cnt", done_cnt, 3);
      chk("t3_queue_empty", expq.size(), 0);

      // Source restarts mid-capture; a request during capture is ignored.
      scale_in = 2'b00;
      req_pulse();
      send_rows(0, OW, 0, 3, 1, 1, 1'b1);
      req_pulse();
      send_rows(0, OW, 3, 5, 1, 1, 1'b1);
      idle(3);
      drive_pix(0, 0, 9);
      idle(1);
      chk("t4_err_pulse", int'(frame_err_out), 1);
      chk("t4_busy_at_err", int'(busy_out), 0);
      idle(1);
      chk("t4_err_single", int'(frame_err_out), 0);
      chk("t4_busy_after", int'(busy_out), 0);
      send_rows(0, OW, 0, OH, 1, 1, 1'b0);
      idle(6);
      chk("t4_err_cnt", err_cnt, 1);
      chk("t4_done_cnt", done_cnt, 3);
      chk("t4_queue_empty", expq.size(), 0);

      // Reset mid-capture drops the in-flight write.
      scale_in = 2'b11;
      req_pulse();
      send_rows(1, 2 * OW, 0, 5, 2, 2, 1'b1);
      drive_pix(0, 5, 50);
      drive_pix(1, 5, 60);
      @(negedge clk);
      pixel_valid_in = 1'b0;
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      chk_outputs_zero("t5_after_rst");
      send_rows(1, 2 * OW, 5, 2 * OH, 2, 2, 1'b0);
      idle(6);
      chk("t5_done_cnt", done_cnt, 3);
      chk("t5_queue_empty", expq.size(), 0);

      // New capture: 2x2 stays in force despite scale_in change; h >= 32 discarded.
      scale_in = 2'b11;
      req_pulse();
      send_rows(0, 40, 0, 4, 2, 2, 1'b1);
      scale_in = 2'b00;
      send_rows(0, 40, 4, 2 * OH, 2, 2, 1'b1);
      idle(6);
      chk("t6_done_cnt", done_cnt, 4);
      chk("t6_err_cnt", err_cnt, 1);
      chk("t6_queue_empty", expq.size(), 0);
      chk("t6_busy_after", int'(busy_out), 0);

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
